// File: rtl/router_inject_port_if.sv
// Injection-link bundle between the PE/switch side and the router input port.
interface router_inject_port_if;
  logic [19:0] flit_in;
  logic        vi;
  logic        co;
  logic [19:0] flit_out;
  logic        vo;
  logic [4:0]  req;
  logic        grant;
  logic        err;

  modport master (output flit_in, vi, grant, input  co, flit_out, vo, req, err);
  modport slave  (input  flit_in, vi, grant, output co, flit_out, vo, req, err);
endinterface

// File: rtl/router_inject_port.sv
// Router local-injection input port: flit FIFO with credit return, XY route
// computation on head flits, and per-packet output request hold.
module router_inject_port #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [3:0]           position,
  router_inject_port_if.slave  bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ROUTE = 1'b1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [19:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [0:0]       state;
  logic [4:0]       req_q, route;
  logic             first_q, co_q, err_q;
  logic [19:0]      front;
  logic             empty, full, vo_c, fwd, orphan, pop, push, drop, route_go, mid_head;

  assign front = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // type bit 18 marks head/single, bit 19 marks tail/single
  assign vo_c     = (state == ROUTE) && !empty;
  assign fwd      = vo_c && bus.grant;
  assign orphan   = (state == IDLE) && !empty && !front[18];
  assign route_go = (state == IDLE) && !empty &&  front[18];
  assign mid_head = fwd && front[18] && !first_q;
  assign pop      = fwd || orphan;
  assign push     = bus.vi && (!full || pop);
  assign drop     = bus.vi && !push;

  // XY routing, x resolved first; no wrap-around
  always_comb begin
    route = 5'b10000;
    if      (front[17:16] > position[3:2]) route = 5'b00100;
    else if (front[17:16] < position[3:2]) route = 5'b01000;
    else if (front[15:14] > position[1:0]) route = 5'b00001;
    else if (front[15:14] < position[1:0]) route = 5'b00010;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.flit_in;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= IDLE;
      req_q   <= '0;
      first_q <= 1'b0;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      co_q  <= pop;
      if (drop || orphan || mid_head) err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (route_go) begin
            state   <= ROUTE;
            req_q   <= route;
            first_q <= 1'b1;
          end
        end
        default: begin
          if (fwd) begin
            first_q <= 1'b0;
            if (front[19]) begin
              state <= IDLE;
              req_q <= '0;
            end
          end
        end
      endcase
    end
  end

  assign bus.co       = co_q;
  assign bus.vo       = vo_c;
  assign bus.req      = req_q;
  assign bus.err      = err_q;
  assign bus.flit_out = vo_c ? front : '0;
endmodule

// File: doc/router_inject_port.md
Name: router_inject_port

Overview:
- Router-side receiver for the local injection link driven by the processor element: flits with a valid strobe come in, and one credit is returned per freed buffer slot.
- Buffers flits in a small FIFO and performs XY route computation on head flits.
- Holds the computed output request for the whole packet until the tail flit is dequeued, then presents flits to the crossbar/switch allocator.
- Acts as the credit-returning counterpart to the PE's credit-consuming inject interface.

Parameters:
- DEPTH, 4, buffer slots; also the sender's initial credit count (power of 2, ≥2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- position  in  4  this node's coordinates: [3:2]=x, [1:0]=y.
- flit_in  in  20  flit from the PE.
- vi  in  1  flit_in valid; one flit per cycle.
- co  out  1  credit return; one-cycle pulse per freed slot.
- flit_out  out  20  flit at FIFO head.
- vo  out  1  flit_out valid toward the switch.
- req  out  5  one-hot output request: [0]=N(y+1), [1]=S(y−1), [2]=E(x+1), [3]=W(x−1), [4]=local.
- grant  in  1  switch accepts flit_out this cycle.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Flit format:
  - [19:18] type: 00 body, 01 head, 10 tail, 11 single (head+tail).
  - Head/single flits: [17:16] dest x, [15:14] dest y.
  - Remaining bits are payload, passed through untouched.
- Reset (asynchronous, RST=1):
  - FIFO emptied, pointers and count 0, FSM=IDLE.
  - co=0, vo=0, req=0, err=0, flit_out=0.
  - Reset mid-packet discards all buffered flits and the held route. The sender also resets, restoring DEPTH credits.
- Write:
  - A flit with vi=1 is written at the clock edge.
  - It is visible at flit_out no earlier than the next cycle (1-cycle minimum latency).
- Accept rule:
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the flit is dropped, err is set, and no credit is ever returned for it.
- Pop:
  - Occurs when vo=1 and grant=1, or on a discard (see IDLE).
  - Each pop makes co pulse high for exactly one cycle, on the cycle after the pop edge (registered).
  - Pops on consecutive cycles produce co high on consecutive cycles.
- FSM state IDLE:
  - vo=0, req=0.
  - FIFO non-empty with a head/single flit at the front: compute the route from the front flit. At the next edge, latch req and go to ROUTE.
  - FIFO non-empty with a body/tail flit at the front (orphan): pop and discard it, return a credit, set err, remain IDLE.
- Route computation (XY, x first):
  - dest x > pos x → E.
  - dest x < pos x → W.
  - Otherwise dest y > pos y → N.
  - dest y < pos y → S.
  - Otherwise local.
  - Comparisons are unsigned 2-bit; there is no wrap-around (mesh, not torus).
- FSM state ROUTE:
  - req held constant; vo = FIFO non-empty; flit_out = front flit.
  - grant while vo=0 is ignored.
  - When the popped flit is tail or single, go to IDLE at the same edge; req=0 from the next cycle.
  - A single flit therefore spends one cycle in IDLE and at least one cycle in ROUTE.
  - A head flit arriving mid-packet is forwarded as an ordinary flit and sets err.
- Count update on a simultaneous accepted push and pop: count unchanged.
- err clears only on reset.

Test Plan:
- Reset: assert RST mid-cycle → co, vo, req, err go to 0 immediately (asynchronously). Release, then drive 4 flits with no grant → all accepted, co never pulses.
- Single-flit local delivery: position=4'b0101; inject single flit (type 11, dest 01/01) → req=5'b10000. With grant=1 on the first vo cycle, co pulses once on the following cycle. req returns to 0 the cycle after the pop.
- East routing with stalls: position=4'b0000; inject head (dest x=2, y=3), body, tail; grant toggles 1,0,1,1 → req=5'b00100 for the whole packet. Flits leave in order, co pulses exactly 3 times, and FSM returns to IDLE after the tail pop.
- Overflow: fill 4 flits, grant=0, then a 5th vi → 5th flit dropped and err=1. Repeat with a full FIFO and a same-cycle pop → flit accepted, err unchanged.
- Orphan flit: inject a body flit while IDLE → discarded without vo, co pulses once, err=1. A following single flit routes normally.
- Reset mid-packet: head and body buffered, route N held; assert RST → FIFO empty, req=0. Then a new single flit routes correctly with a fresh credit count.
